// File: rtl/lfsr_seq_checker_if.sv
// Sample stream into the LFSR sequence checker and its status outputs.
// in_valid qualifies in_data; there is no ready: a sample is consumed on every rising edge with in_valid=1.
interface lfsr_seq_checker_if #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             lock;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic [WIDTH-1:0] period;
    logic             period_valid;

    modport master (
        output in_valid, in_data,
        input  lock, err_pulse, err_count, period, period_valid
    );

    modport slave (
        input  in_valid, in_data,
        output lock, err_pulse, err_count, period, period_valid
    );
endinterface

// File: rtl/lfsr_seq_checker.sv
// Self-seeding LFSR stream checker: search, acquire, lock, count errors.
// Define LFSR_CHK_PERIOD_EN to build the sequence-period measurement.
module lfsr_seq_checker #(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(4'b1100),
    parameter int               LOCK_CNT = 4,
    parameter int               ERR_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    lfsr_seq_checker_if.slave   bus,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    localparam logic [3:0] LOCK_CNT_L = 4'(LOCK_CNT);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic [3:0]       match_cnt_q, match_cnt_d;
    logic             miss_q, miss_d;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    logic [WIDTH-1:0] pred;
    logic [3:0]       match_cnt_inc;
    logic             match;
    logic             sample_zero;

    assign pred          = {ref_q[WIDTH-2:0], ^(ref_q & TAPS)};
    assign match         = (bus.in_data == pred);
    assign sample_zero   = (bus.in_data == '0);
    assign match_cnt_inc = match_cnt_q + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SEARCH;
            ref_q       <= '0;
            match_cnt_q <= '0;
            miss_q      <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            ref_q       <= ref_d;
            match_cnt_q <= match_cnt_d;
            miss_q      <= miss_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.in_valid) begin
            case (state_q)
                SEARCH:  if (!sample_zero) state_d = ACQUIRE;
                ACQUIRE: begin
                    if (match && (match_cnt_inc == LOCK_CNT_L)) state_d = LOCKED;
                    else if (!match && sample_zero)            state_d = SEARCH;
                end
                LOCKED:  if (!match && miss_q) state_d = SEARCH;
                default: state_d = SEARCH;
            endcase
        end
    end

    // Once locked the predictor free-runs on its own output, so corrupt samples never reseed it.
    always_comb begin
        ref_d       = ref_q;
        match_cnt_d = match_cnt_q;
        miss_d      = miss_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;
        if (bus.in_valid) begin
            case (state_q)
                SEARCH: begin
                    if (!sample_zero) begin
                        ref_d       = bus.in_data;
                        match_cnt_d = '0;
                    end
                end
                ACQUIRE: begin
                    if (match) begin
                        ref_d       = bus.in_data;
                        match_cnt_d = match_cnt_inc;
                    end else begin
                        match_cnt_d = '0;
                        if (!sample_zero) ref_d = bus.in_data;
                    end
                end
                LOCKED: begin
                    ref_d = pred;
                    if (match) begin
                        miss_d = 1'b0;
                    end else begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
                        miss_d = ~miss_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.lock      = (state_q == LOCKED);
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_count = err_count_q;
    assign state_dbg     = state_q;

`ifdef LFSR_CHK_PERIOD_EN
    logic [WIDTH-1:0] anchor_q, anchor_d;
    logic             anchor_ok_q, anchor_ok_d;
    logic [WIDTH-1:0] pcnt_q, pcnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             period_valid_q, period_valid_d;
    logic [WIDTH-1:0] pcnt_inc;

    assign pcnt_inc = (pcnt_q == '1) ? pcnt_q : pcnt_q + WIDTH'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            anchor_q       <= '0;
            anchor_ok_q    <= 1'b0;
            pcnt_q         <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
        end else begin
            anchor_q       <= anchor_d;
            anchor_ok_q    <= anchor_ok_d;
            pcnt_q         <= pcnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
        end
    end

    // A mismatch invalidates the anchor; the next matching sample becomes the new reference point.
    always_comb begin
        anchor_d       = anchor_q;
        anchor_ok_d    = anchor_ok_q;
        pcnt_d         = pcnt_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        if (bus.in_valid) begin
            if (state_q == ACQUIRE && state_d == LOCKED) begin
                anchor_d    = bus.in_data;
                anchor_ok_d = 1'b1;
                pcnt_d      = '0;
            end else if (state_q == LOCKED) begin
                if (!match) begin
                    pcnt_d      = '0;
                    anchor_ok_d = 1'b0;
                end else if (!anchor_ok_q) begin
                    anchor_d    = bus.in_data;
                    anchor_ok_d = 1'b1;
                    pcnt_d      = '0;
                end else if (bus.in_data == anchor_q) begin
                    period_d       = pcnt_inc;
                    period_valid_d = 1'b1;
                    pcnt_d         = '0;
                end else begin
                    pcnt_d = pcnt_inc;
                end
            end
        end
    end

    assign bus.period       = period_q;
    assign bus.period_valid = period_valid_q;
`else
    assign bus.period       = '0;
    assign bus.period_valid = 1'b0;
`endif

endmodule
